// File: rtl/prog_cpu_param.sv
// Programmable accumulator core: words are strobed into program memory in LOAD,
// then executed two cycles per instruction (FETCH/EXEC) until HLT.
module prog_cpu_param #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = $clog2(DEPTH),
    parameter int unsigned INSTR_W = 3 + DATA_W,
    parameter int unsigned OUT_W   = 2 * DATA_W
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               enable,
    input  logic               run,
    input  logic [INSTR_W-1:0] instruc,
    output logic [OUT_W-1:0]   port_1,
    output logic               carry,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted,
    output logic               load_full
);

    typedef enum logic [1:0] {StLoad, StFetch, StExec, StHalt} state_e;
    typedef enum logic [2:0] {
        OpNop, OpLdi, OpAdd, OpSub, OpOutl, OpOuth, OpJnz, OpHlt
    } opc_e;

    state_e              state_q, state_d;
    logic [INSTR_W-1:0]  mem_q [DEPTH];
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, pc_q, pc_d, mem_waddr;
    logic [DATA_W-1:0]   acc_q, acc_d, imm;
    logic [OUT_W-1:0]    port_q, port_d;
    logic                carry_q, carry_d, load_full_q, load_full_d, mem_we;
    logic                enable_q, run_q, en_arm_q, run_arm_q, en_stb, run_stb;
    logic [DATA_W:0]     sum;
    opc_e                opc;

    // A strobe needs the input to have been seen low since reset, so a level
    // held across reset release does not count as an edge.
    assign en_stb  = enable & ~enable_q & en_arm_q;
    assign run_stb = run & ~run_q & run_arm_q;
    assign opc     = opc_e'(ir_q[INSTR_W-1 -: 3]);
    assign imm     = ir_q[DATA_W-1:0];
    assign sum     = {1'b0, acc_q} + {1'b0, imm};

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad:  if (run_stb) state_d = StFetch;
            StFetch: state_d = StExec;
            StExec:  state_d = (opc == OpHlt) ? StHalt : StFetch;
            StHalt: begin
                if (run_stb) state_d = StFetch;
                else if (en_stb) state_d = StLoad;
            end
            default: state_d = StLoad;
        endcase
    end

    always_comb begin
        busy   = (state_q == StFetch) || (state_q == StExec);
        halted = (state_q == StHalt);
    end

    assign port_1    = port_q;
    assign carry     = carry_q;
    assign pc        = pc_q;
    assign load_full = load_full_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        load_full_d = load_full_q;
        pc_d        = pc_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        port_d      = port_q;
        ir_d        = ir_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_q;
        unique case (state_q)
            StLoad: begin
                if (run_stb) begin
                    pc_d    = '0;
                    acc_d   = '0;
                    carry_d = 1'b0;
                end else if (en_stb && !load_full_q) begin
                    mem_we = 1'b1;
                    if (wr_ptr_q == ADDR_W'(DEPTH - 1)) load_full_d = 1'b1;
                    else wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                end
            end
            StFetch: ir_d = mem_q[pc_q];
            StExec: begin
                pc_d = pc_q + ADDR_W'(1);
                unique case (opc)
                    OpNop:  ;
                    OpLdi:  acc_d = imm;
                    OpAdd:  {carry_d, acc_d} = sum;
                    OpSub: begin
                        acc_d   = acc_q - imm;
                        carry_d = (acc_q < imm);
                    end
                    OpOutl: port_d[DATA_W-1:0] = acc_q;
                    OpOuth: port_d[OUT_W-1:DATA_W] = acc_q;
                    OpJnz:  if (acc_q != '0) pc_d = imm[ADDR_W-1:0];
                    OpHlt:  pc_d = pc_q;
                    default: ;
                endcase
            end
            StHalt: begin
                if (run_stb) begin
                    pc_d    = '0;
                    acc_d   = '0;
                    carry_d = 1'b0;
                end else if (en_stb) begin
                    // Reload starts over at word 0 and writes it with this strobe.
                    mem_we      = 1'b1;
                    mem_waddr   = '0;
                    wr_ptr_d    = ADDR_W'(1);
                    load_full_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            wr_ptr_q    <= '0;
            load_full_q <= 1'b0;
            pc_q        <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            port_q      <= '0;
            ir_q        <= '0;
            enable_q    <= 1'b0;
            run_q       <= 1'b0;
            en_arm_q    <= 1'b0;
            run_arm_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            load_full_q <= load_full_d;
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            port_q      <= port_d;
            ir_q        <= ir_d;
            enable_q    <= enable;
            run_q       <= run;
            en_arm_q    <= en_arm_q | ~enable;
            run_arm_q   <= run_arm_q | ~run;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[mem_waddr] <= instruc;
        end
    end

endmodule

// File: tb/tb_prog_cpu_param.sv
// Scoreboard bench for prog_cpu_param: expected port changes and halt snapshots
// are queued by the stimulus and checked by an independent monitor.
module tb_prog_cpu_param;

    typedef struct packed {
        logic [7:0] port;
        logic       carry;
        logic [3:0] pc;
    } halt_t;

    logic       clk = 1'b0, clear = 1'b0, enable = 1'b0, run = 1'b0;
    logic [6:0] instruc = '0;
    logic [7:0] port_1;
    logic       carry, busy, halted, load_full;
    logic [3:0] pc;

    int    n_checks = 0, n_fail = 0;
    logic [7:0] port_exp_q [$];
    halt_t      halt_exp_q [$];

    prog_cpu_param dut (
        .clk(clk), .clear(clear), .enable(enable), .run(run), .instruc(instruc),
        .port_1(port_1), .carry(carry), .pc(pc), .busy(busy), .halted(halted),
        .load_full(load_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear = 1'b0; enable = 1'b0; run = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_word(input logic [6:0] w);
        @(negedge clk);
        instruc = w; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic start_run();
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_halt(output int cycles);
        cycles = 0;
        while (!halted && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    // Monitor: every change of port_1 and every HALT entry pops the scoreboard.
    initial begin
        logic [7:0] prev_port = '0;
        logic       prev_halted = 1'b0;
        forever begin
            @(negedge clk);
            if (!clear) begin
                prev_port   = port_1;
                prev_halted = halted;
            end else begin
                if (port_1 !== prev_port) begin
                    if (port_exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL port_change: got %0h, expected no change", port_1);
                    end else begin
                        check("port_change", 32'(port_1), 32'(port_exp_q.pop_front()));
                    end
                    prev_port = port_1;
                end
                if (halted && !prev_halted) begin
                    if (halt_exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL halt_event: got pc %0h, expected no halt", pc);
                    end else begin
                        halt_t e;
                        e = halt_exp_q.pop_front();
                        check("halt_port", 32'(port_1), 32'(e.port));
                        check("halt_carry", 32'(carry), 32'(e.carry));
                        check("halt_pc", 32'(pc), 32'(e.pc));
                    end
                end
                prev_halted = halted;
            end
        end
    end

    initial begin
        logic [6:0] words [17];
        int cyc;
        do_reset();
        check("rst_port", 32'(port_1), 32'd0);
        check("rst_busy_halted", {busy, halted, load_full, carry}, 32'd0);
        check("rst_pc", 32'(pc), 32'd0);

        // Add/output, with FETCH-to-HALT latency
        port_exp_q.push_back(8'h08);
        halt_exp_q.push_back('{port: 8'h08, carry: 1'b0, pc: 4'd3});
        load_word(7'h15); load_word(7'h23); load_word(7'h40); load_word(7'h70);
        start_run();
        check("busy_after_run", 32'(busy), 32'd1);
        wait_halt(cyc);
        check("halt_latency", 32'(cyc), 32'd8);

        // Carry out of ADD, then reload from HALT and use OUTH
        do_reset();
        halt_exp_q.push_back('{port: 8'h00, carry: 1'b1, pc: 4'd3});
        load_word(7'h1F); load_word(7'h21); load_word(7'h50); load_word(7'h70);
        start_run();
        wait_halt(cyc);
        port_exp_q.push_back(8'hF0);
        halt_exp_q.push_back('{port: 8'hF0, carry: 1'b0, pc: 4'd2});
        load_word(7'h1F);
        check("halt_to_load", {busy, halted}, 32'd0);
        load_word(7'h50); load_word(7'h70);
        start_run();
        wait_halt(cyc);

        // Countdown loop through JNZ
        do_reset();
        port_exp_q.push_back(8'h02); port_exp_q.push_back(8'h01); port_exp_q.push_back(8'h00);
        halt_exp_q.push_back('{port: 8'h00, carry: 1'b0, pc: 4'd4});
        load_word(7'h13); load_word(7'h31); load_word(7'h40); load_word(7'h61);
        load_word(7'h70);
        start_run();
        wait_halt(cyc);

        // Load full: 17th word must not land anywhere
        do_reset();
        words[0] = 7'h1A; words[1] = 7'h40; words[2] = 7'h70; words[16] = 7'h15;
        for (int i = 3; i < 16; i++) words[i] = 7'h20 + 7'(i);
        for (int i = 0; i < 17; i++) begin
            load_word(words[i]);
            if (i == 14) check("load_full_at_15", 32'(load_full), 32'd0);
            if (i == 15) check("load_full_at_16", 32'(load_full), 32'd1);
        end
        check("load_full_at_17", 32'(load_full), 32'd1);
        port_exp_q.push_back(8'h0A);
        halt_exp_q.push_back('{port: 8'h0A, carry: 1'b0, pc: 4'd2});
        start_run();
        wait_halt(cyc);

        // Held enable writes one word
        do_reset();
        port_exp_q.push_back(8'h07);
        halt_exp_q.push_back('{port: 8'h07, carry: 1'b0, pc: 4'd2});
        @(negedge clk);
        instruc = 7'h17; enable = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        load_word(7'h40); load_word(7'h70);
        start_run();
        wait_halt(cyc);

        // Enable high across reset release: the HLT word must not be written
        @(negedge clk);
        clear = 1'b0; enable = 1'b1; instruc = 7'h70;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        port_exp_q.push_back(8'h03);
        halt_exp_q.push_back('{port: 8'h03, carry: 1'b0, pc: 4'd2});
        load_word(7'h13); load_word(7'h40); load_word(7'h70);
        start_run();
        wait_halt(cyc);

        // Async reset during EXEC of ADD, then NOP sweep with pc wrap
        do_reset();
        port_exp_q.push_back(8'h0F);
        load_word(7'h1F); load_word(7'h40); load_word(7'h21);
        start_run();
        repeat (5) @(negedge clk);
        clear = 1'b0;
        #1;
        check("midrun_port", 32'(port_1), 32'd0);
        check("midrun_flags", {busy, halted, load_full, carry}, 32'd0);
        check("midrun_pc", 32'(pc), 32'd0);
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        start_run();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k >= 30 && k <= 33) check("nop_pc_wrap", 32'(pc), 32'((k / 2) % 16));
        end
        check("nop_busy", {busy, halted}, 32'd2);

        repeat (4) @(negedge clk);
        check("port_queue_empty", 32'(port_exp_q.size()), 32'd0);
        check("halt_queue_empty", 32'(halt_exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_cpu_param.md
Name: prog_cpu_param

Overview:
- Parametrised successor to the 4-bit programmable accumulator core.
- Two modes:
  - LOAD: instruction words are strobed in one at a time with `enable`.
  - RUN: executes the stored program on a DATA_W-bit accumulator with carry, driving a 2×DATA_W output port.
- Width, program depth and instruction width are generic.
- Adds conditional branching, halt/restart and load-full detection.

Parameters:
- DATA_W, 4: accumulator/immediate width.
- DEPTH, 16: program memory words. Power of two, ≥2.
- ADDR_W, $clog2(DEPTH): PC/write-pointer width. Constraint: ADDR_W ≤ DATA_W.
- INSTR_W, 3+DATA_W: instruction width, {opc[2:0], imm[DATA_W-1:0]}.
- OUT_W, 2*DATA_W: output port width.

Ports:
- clk  in  1  single clock, rising edge.
- clear  in  1  asynchronous active-low reset.
- enable  in  1  load strobe; rising-edge detected.
- run  in  1  start strobe; rising-edge detected.
- instruc  in  INSTR_W  instruction word written on an enable strobe.
- port_1  out  OUT_W  output port.
- carry  out  1  carry/borrow flag.
- pc  out  ADDR_W  program counter.
- busy  out  1  high in FETCH or EXEC.
- halted  out  1  high in HALT.
- load_full  out  1  all DEPTH words written since the last load start.

Behaviour:
- **Reset** (clear=0, async):
  - state=LOAD; wr_ptr=0, pc=0, A=0, carry=0, port_1=0.
  - load_full=0, busy=0, halted=0; enable_q=0, run_q=0.
  - All memory words cleared to 0 (NOP).
- **Strobe detection:**
  - A strobe is `sig & ~sig_q` sampled at a clk edge; sig_q registers sig every cycle.
  - A level held high across reset release produces no strobe until it falls and rises again.
- **LOAD:**
  - enable strobe with load_full=0: mem[wr_ptr]<=instruc, then wr_ptr++.
  - When wr_ptr would reach DEPTH: load_full<=1 and wr_ptr holds. Further strobes are ignored; memory is unchanged.
  - run strobe: pc<=0, A<=0, carry<=0, then go to FETCH next cycle.
  - If run and enable strobe in the same cycle, run wins and no write occurs.
- **FETCH** (1 cycle): ir<=mem[pc]; then go to EXEC.
- **EXEC** (1 cycle): decode ir. Default pc<=pc+1, wrapping DEPTH-1→0. Then go to FETCH, except HLT.
  - 000 NOP: no change.
  - 001 LDI: A<=imm; carry unchanged.
  - 010 ADD: {carry,A}<=A+imm, DATA_W+1-bit result.
  - 011 SUB: A<=A−imm mod 2^DATA_W; carry<=(A<imm), i.e. borrow.
  - 100 OUTL: port_1[DATA_W-1:0]<=A.
  - 101 OUTH: port_1[OUT_W-1:DATA_W]<=A.
  - 110 JNZ: if A≠0, pc<=imm[ADDR_W-1:0]; else pc+1.
  - 111 HLT: pc holds at the HLT address; go to HALT.
- **Timing:**
  - Two cycles per instruction.
  - Port/flag updates are visible the cycle after the EXEC edge.
  - enable and run strobes are ignored in FETCH and EXEC.
- **HALT:**
  - run strobe: restart as from LOAD (pc=0, A=0, carry=0). port_1 is retained; memory is retained.
  - enable strobe: return to LOAD with wr_ptr=0 and load_full=0; that same strobe writes instruc to mem[0] and sets wr_ptr=1.
  - run wins over a simultaneous enable.
- **Outputs:** busy=(FETCH|EXEC); halted=(state==HALT).
- **Reset mid-operation:** any state returns to the reset values immediately; an in-flight instruction has no effect.
- **Program without HLT:** runs forever, with pc wrapping modulo DEPTH.

Test Plan (defaults: DATA_W=4, DEPTH=16, INSTR_W=7):
1. **Add/output:**
   - Stimulus: load 0x15 (LDI 5), 0x23 (ADD 3), 0x40 (OUTL), 0x70 (HLT); run strobe.
   - Required: port_1=0x08, carry=0, halted=1, pc=3; HALT entered 8 cycles after first FETCH.
2. **Carry:**
   - Stimulus: load 0x1F, 0x21, 0x50, 0x70; run.
   - Required: A=0, carry=1, port_1=0x00; then load 0x1F, 0x50, 0x70 after an enable strobe from HALT, run → port_1=0xF0.
3. **Loop/branch:**
   - Stimulus: load 0x13, 0x31, 0x40, 0x61, 0x70; run.
   - Required: port_1[3:0] sequence 2,1,0; JNZ taken twice; final halted=1, pc=4, carry=0.
4. **Load full:**
   - Stimulus: 17 enable strobes with distinct words.
   - Required: load_full=1 after the 16th; the 17th is ignored (mem[0] still holds the first word; readback by running LDI/OUTL words).
5. **Strobe edge/hold:**
   - Stimulus: enable held high for 3 clocks.
   - Required: exactly one word written. enable high during reset release → no write until re-asserted.
6. **Async reset mid-run:**
   - Stimulus: clear=0 during EXEC of an ADD.
   - Required: immediately (no clock) port_1=0, carry=0, pc=0, busy=0, halted=0, load_full=0; after release, running an unloaded memory executes NOPs with pc wrapping 15→0.
